// File: rtl/nim_sum_sequencer_if.sv
// nim_sum_sequencer_if: digit stream handshake, datapath control
// and status signals between the sequencer and its environment.
interface nim_sum_sequencer_if;
   logic        start;
   logic        digit_valid;
   logic [3:0]  digit_data;
   logic        digit_ready;
   logic [31:0] alu_result;
   logic [4:0]  rgr1;
   logic [4:0]  rgr2;
   logic [4:0]  rgw1;
   logic        reg_write;
   logic        alu_src;
   logic [3:0]  alu_ctrl;
   logic [31:0] immediate;
   logic [31:0] address;
   logic        mem_write;
   logic        mem_read;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        digit_err;

   modport master (
      input  start, digit_valid, digit_data, alu_result,
      output digit_ready, rgr1, rgr2, rgw1, reg_write,
      output alu_src, alu_ctrl, immediate, address,
      output mem_write, mem_read, busy, done, sum, digit_err
   );

   modport slave (
      output start, digit_valid, digit_data, alu_result,
      input  digit_ready, rgr1, rgr2, rgw1, reg_write,
      input  alu_src, alu_ctrl, immediate, address,
      input  mem_write, mem_read, busy, done, sum, digit_err
   );
endinterface

// File: rtl/nim_sum_sequencer.sv
// nim_sum_sequencer: loads a digit stream into the register file,
// sums it through the ALU into an accumulator and stores the total.
module nim_sum_sequencer #(
   parameter int          NUM_DIGITS = 6,
   parameter int          BASE_REG   = 20,
   parameter int          ACC_REG    = 31,
   parameter logic [31:0] MEM_ADDR   = 32'h0
) (
   input  logic                clk,
   input  logic                rst_n,
   nim_sum_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, LOAD, LOAD_WR, CLEAR, ACCUM, STORE, DONE
   } state_t;

   localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);
   localparam logic [4:0] BASE = 5'(BASE_REG);
   localparam logic [4:0] ACC  = 5'(ACC_REG);

   state_t      state, state_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [3:0]  digit, digit_nxt;
   logic        err_nxt;
   logic        ready_n, alu_src_n, reg_write_n;
   logic        mem_write_n, mem_read_n, done_n;
   logic [4:0]  rgr1_n, rgr2_n, rgw1_n;
   logic [31:0] imm_n, addr_n;

   assign bus.alu_ctrl = 4'b0000;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      digit_nxt = digit;
      err_nxt   = bus.digit_err;
      unique case (state)
         IDLE: if (bus.start) begin
            idx_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = LOAD;
         end
         LOAD: if (bus.digit_valid) begin
            digit_nxt = bus.digit_data;
            if (bus.digit_data > 4'd9) err_nxt = 1'b1;
            state_nxt = LOAD_WR;
         end
         LOAD_WR: if (idx == LAST) begin
            idx_nxt   = '0;
            state_nxt = CLEAR;
         end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = LOAD;
         end
         CLEAR: state_nxt = ACCUM;
         ACCUM: if (idx == LAST) begin
            idx_nxt   = '0;
            state_nxt = STORE;
         end else begin
            idx_nxt   = idx + 4'd1;
         end
         STORE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered
   // copies line up with the state they belong to.
   always_comb begin
      ready_n     = 1'b0;
      alu_src_n   = 1'b0;
      reg_write_n = 1'b0;
      mem_write_n = 1'b0;
      mem_read_n  = 1'b0;
      done_n      = 1'b0;
      rgr1_n      = '0;
      rgr2_n      = '0;
      rgw1_n      = '0;
      imm_n       = '0;
      addr_n      = '0;
      unique case (state_nxt)
         IDLE: ;
         LOAD: ready_n = 1'b1;
         LOAD_WR: begin
            alu_src_n   = 1'b1;
            imm_n       = {28'd0, digit_nxt};
            rgw1_n      = BASE + {1'b0, idx_nxt};
            reg_write_n = 1'b1;
         end
         CLEAR: begin
            alu_src_n   = 1'b1;
            rgw1_n      = ACC;
            reg_write_n = 1'b1;
         end
         ACCUM: begin
            rgr1_n      = ACC;
            rgr2_n      = BASE + {1'b0, idx_nxt};
            rgw1_n      = ACC;
            reg_write_n = 1'b1;
         end
         STORE: begin
            rgr1_n      = ACC;
            addr_n      = MEM_ADDR;
            mem_write_n = 1'b1;
         end
         DONE: begin
            done_n     = 1'b1;
            mem_read_n = 1'b1;
            addr_n     = MEM_ADDR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         idx             <= '0;
         digit           <= '0;
         bus.digit_err   <= 1'b0;
         bus.digit_ready <= 1'b0;
         bus.alu_src     <= 1'b0;
         bus.reg_write   <= 1'b0;
         bus.mem_write   <= 1'b0;
         bus.mem_read    <= 1'b0;
         bus.done        <= 1'b0;
         bus.busy        <= 1'b0;
         bus.rgr1        <= '0;
         bus.rgr2        <= '0;
         bus.rgw1        <= '0;
         bus.immediate   <= '0;
         bus.address     <= '0;
         bus.sum         <= '0;
      end else begin
         state           <= state_nxt;
         idx             <= idx_nxt;
         digit           <= digit_nxt;
         bus.digit_err   <= err_nxt;
         bus.digit_ready <= ready_n;
         bus.alu_src     <= alu_src_n;
         bus.reg_write   <= reg_write_n;
         bus.mem_write   <= mem_write_n;
         bus.mem_read    <= mem_read_n;
         bus.done        <= done_n;
         bus.busy        <= (state_nxt != IDLE);
         bus.rgr1        <= rgr1_n;
         bus.rgr2        <= rgr2_n;
         bus.rgw1        <= rgw1_n;
         bus.immediate   <= imm_n;
         bus.address     <= addr_n;
         if (state == STORE) bus.sum <= bus.alu_result;
      end
   end
endmodule
